// File: rtl/apb_init_pkg.sv
// Shared types and defaults for the APB command initiator.
// Holds the FSM state encoding and the default wait timeout.
package apb_init_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/apb_cmd_initiator.sv
// APB requester: takes one command at a time, runs a SETUP/ACCESS
// transfer with an optional wait timeout, and holds the response.
module apb_cmd_initiator
  import apb_init_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // A zero timeout still gets a 1-bit counter so the logic stays legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  to_q, to_d;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_d     = to_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          rdata_d = pwrite_q ? '0 : PRDATA;
          err_d   = PSLVERR;
          to_d    = 1'b0;
          state_d = RESP;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
          if (TIMEOUT > 0 && cnt_d == CW'(TIMEOUT)) begin
            rdata_d = '0;
            err_d   = 1'b1;
            to_d    = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE     = (state_q == ACCESS);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Bench for apb_cmd_initiator: directed table, random transfers
// against an outcome model, and reset corner cases.
module tb_apb_cmd_initiator;

  localparam int TMO = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  apb_cmd_initiator #(.TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;
  } txn_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic txn_t mk(logic wr, logic [31:0] a, logic [31:0] wd,
                              int w, logic [31:0] pr, logic se, int h,
                              logic [31:0] er, logic ee, logic et, int ea);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = wd; t.waits = w;
    t.prdata = pr; t.slverr = se; t.hold = h;
    t.exp_rdata = er; t.exp_err = ee; t.exp_to = et; t.exp_acc = ea;
    return t;
  endfunction

  // Outcome of a transfer from the slave's wait count alone.
  function automatic txn_t ref_model(txn_t t);
    bit to;
    to = (TMO > 0) && (t.waits >= TMO);
    t.exp_to    = to;
    t.exp_err   = to | t.slverr;
    t.exp_acc   = to ? TMO : t.waits + 1;
    t.exp_rdata = (to || t.wr) ? 32'h0 : t.prdata;
    return t;
  endfunction

  task automatic run_txn(input txn_t t, input string nm);
    int  cyc, acc, setups, lat, hcnt;
    bit  got, done, stab;
    logic [31:0] rd;
    logic e, to;
    cyc = 0; acc = 0; setups = 0; lat = 0; hcnt = 0;
    got = 0; done = 0; stab = 1; rd = '0; e = 0; to = 0;
    chk({nm, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = t.wr;
    cmd_addr = t.addr; cmd_wdata = t.wdata;
    while (!done && cyc < 200) begin
      @(posedge PCLK); #1;
      cyc++;
      if (cyc == 1) begin
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = $urandom;
      end
      if (PSEL) begin
        if (PADDR !== t.addr || PWRITE !== t.wr || PWDATA !== t.wdata)
          stab = 0;
      end
      if (PSEL && PENABLE) begin
        acc++;
        PREADY  = (acc > t.waits);
        PRDATA  = t.prdata;
        PSLVERR = t.slverr;
      end else begin
        if (PSEL) setups++;
        PREADY  = $urandom;
        PRDATA  = $urandom;
        PSLVERR = 1'b1;
      end
      if (rsp_valid) begin
        if (!got) begin
          got = 1; lat = cyc;
          rd = rsp_rdata; e = rsp_err; to = rsp_timeout;
        end else if (rsp_rdata !== rd || rsp_err !== e ||
                     rsp_timeout !== to) begin
          stab = 0;
        end
        if (cmd_ready || PSEL) stab = 0;
        rsp_ready = (hcnt >= t.hold);
        hcnt++;
      end else if (got) begin
        done = 1;
        rsp_ready = 1'b0;
        chk({nm, "_idle"}, {31'b0, cmd_ready}, 32'd1);
      end
    end
    chk({nm, "_done"}, {31'b0, done}, 32'd1);
    chk({nm, "_setup"}, setups, 32'd1);
    chk({nm, "_acc"}, acc, t.exp_acc);
    chk({nm, "_lat"}, lat, t.exp_acc + 2);
    chk({nm, "_rdata"}, rd, t.exp_rdata);
    chk({nm, "_err"}, {31'b0, e}, {31'b0, t.exp_err});
    chk({nm, "_to"}, {31'b0, to}, {31'b0, t.exp_to});
    chk({nm, "_stable"}, {31'b0, stab}, 32'd1);
    chk({nm, "_hold"}, hcnt, t.hold + 1);
  endtask

  txn_t tbl[8];
  txn_t r;

  initial begin
    tbl[0] = mk(0, 32'h08, 32'h0, 0, 32'hDEADBEEF, 0, 0,
                32'hDEADBEEF, 0, 0, 1);
    tbl[1] = mk(1, 32'h04, 32'h1234, 3, 32'h5555AAAA, 0, 0,
                32'h0, 0, 0, 4);
    tbl[2] = mk(0, 32'h10, 32'h0, 0, 32'h0000CAFE, 1, 0,
                32'h0000CAFE, 1, 0, 1);
    tbl[3] = mk(0, 32'h20, 32'h0, 100, 32'h11112222, 0, 0,
                32'h0, 1, 1, 16);
    tbl[4] = mk(0, 32'h24, 32'h0, 15, 32'h0000600D, 0, 0,
                32'h0000600D, 0, 0, 16);
    tbl[5] = mk(0, 32'h28, 32'h0, 14, 32'hA5A5A5A5, 0, 1,
                32'hA5A5A5A5, 0, 0, 15);
    tbl[6] = mk(0, 32'h2C, 32'h0, 0, 32'h87654321, 0, 5,
                32'h87654321, 0, 0, 1);
    tbl[7] = mk(1, 32'h30, 32'hFFFF0000, 2, 32'hBAD0BAD0, 1, 2,
                32'h0, 1, 0, 3);

    PRESET = 1'b1; cmd_valid = 0; cmd_write = 0;
    cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    PRDATA = 32'hFFFFFFFF; PREADY = 1; PSLVERR = 1;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_psel", {31'b0, PSEL}, 32'd0);
    chk("rst_penable", {31'b0, PENABLE}, 32'd0);
    chk("rst_pwrite", {31'b0, PWRITE}, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_to", {31'b0, rsp_timeout}, 32'd0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      r.wr     = $urandom;
      r.addr   = $urandom & 32'hFFFF_FFFC;
      r.wdata  = $urandom;
      r.waits  = $urandom_range(0, 20);
      r.prdata = $urandom;
      r.slverr = ($urandom_range(0, 3) == 0);
      r.hold   = $urandom_range(0, 3);
      r = ref_model(r);
      run_txn(r, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of an ACCESS phase.
    cmd_valid = 1; cmd_write = 1;
    cmd_addr = 32'h40; cmd_wdata = 32'h77;
    @(posedge PCLK); #1;
    cmd_valid = 0; PREADY = 0;
    repeat (3) @(posedge PCLK);
    #2;
    chk("mid_penable", {31'b0, PENABLE}, 32'd1);
    PRESET = 1'b1;
    #1;
    chk("arst_psel", {31'b0, PSEL}, 32'd0);
    chk("arst_penable", {31'b0, PENABLE}, 32'd0);
    chk("arst_paddr", PADDR, 32'd0);
    chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge PCLK); #1;
      chk("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    end
    run_txn(tbl[0], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
